fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of the team's ASYNC_FIFO between NUM_REQ producers in the write-clock domain. It grants one requester at a time for a bounded burst, drives the FIFO's Winc/Wrdata, and honours Wfull so the FIFO never overflows. It sits between the producer blocks and the FIFO's write side; the read side is untouched.

## Interface

- NUM_REQ, 4: number of requesters (2..8).
- Data_width, 8: data width; must match the FIFO.
- BURST, 4: max words one owner writes per grant (1..16).
- Wclk  in  1  write-domain clock; all state on rising edge.
- Wrst  in  1  asynchronous active-low reset.
- Req  in  NUM_REQ  per-requester level request; held while requester has a word on its data lane.
- Req_data  in  NUM_REQ*Data_width  flattened lanes; lane i = bits [i*Data_width +: Data_width].
- Ack  out  NUM_REQ  one-hot; Ack[i]=1 means lane i's word is written at this edge; requester advances data or drops Req.
- Gnt  out  NUM_REQ  one-hot registered current owner; 0 when IDLE.
- Wfull  in  1  FIFO full flag.
- Winc  out  1  FIFO write enable.
- Wrdata  out  Data_width  FIFO write data.

## Operation

- State: fsm {IDLE, GRANT}, owner index, last-served pointer last, burst counter cnt (clog2(BURST+1) bits).
- Reset (Wrst=0, immediate): fsm=IDLE, owner=0, last=NUM_REQ-1, cnt=0. Outputs: Winc=0, Ack=0, Gnt=0, Wrdata=0.
- Round-robin pick: first i with Req[i]=1, searching last+1, last+2, … wrapping modulo NUM_REQ; last itself checked last.
- Combinational write: Winc = (fsm==GRANT) & Req[owner] & ~Wfull. Wrdata = lane[owner] when fsm==GRANT, else 0. Ack = Winc ? onehot(owner) : 0.
- IDLE: if |Req, pick winner -> GRANT, owner=winner, cnt=0. Else stay.
- GRANT, per edge:
  - Winc=1 and cnt==BURST-1: burst done -> re-arbitrate.
  - Req[owner]=0: owner released -> re-arbitrate (no write this cycle).
  - Winc=1 otherwise: cnt+1, stay.
  - Wfull=1 with Req[owner]=1: hold; cnt, owner unchanged; no rotation while full.
- Re-arbitrate: last=owner; if |Req, GRANT with new round-robin winner (may be same owner if it is the only requester), cnt=0; else IDLE, cnt=0.
- Gnt = onehot(owner) when fsm==GRANT, else 0.
- Requester lanes not granted are ignored; Req may change any cycle.

## Timing

- Write latency: a word is written at the first rising edge where Winc=1; zero-cycle path Req/Wfull -> Winc/Ack.
- IDLE -> first write: 1 cycle (grant edge, then write at next edge).
- Owner-to-owner switch after a completed burst: no bubble; next owner may write at the edge after the last word of the previous burst.
- Owner dropping Req: 1 bubble cycle, then new owner writes.
- Wfull rising: Winc drops in the same cycle; no write while Wfull=1; resume the first cycle Wfull=0.
- Max throughput: 1 word/Wclk.
- Reset mid-burst: Winc drops asynchronously; the in-flight word is not written; after release, priority restarts at requester 0.

## Test plan

- Reset, Req=0001 held, lane0 = 0x11..0x16 advanced on Ack, BURST=4 -> grant edge, then six consecutive Winc cycles writing 0x11..0x16; Gnt stays 0001; no bubble at word 4/5 boundary.
- Req=0101 both held, Wfull=0 -> writes: 4 from lane0, 4 from lane2, 4 from lane0; Ack alternates in blocks of 4; no gap between blocks.
- Req=1111 after reset -> grant order 0,1,2,3,0 each for 4 words; FIFO contents 0x10+i per lane tag read back in that order.
- Owner 1 writing, Wfull=1 after its 2nd word for 3 cycles -> Winc=0, Ack=0 for 3 cycles, Gnt=0010 held, then 2 more words from lane1 before rotation.
- Owner 0 drops Req after 2 words with Req[3]=1 -> one cycle Winc=0, then Gnt=1000 and lane3 writes.
- Wrst pulsed low mid-burst (owner 2, cnt=2) -> Winc/Gnt/Ack 0 immediately; after release with Req=0110 -> requester 1 granted first.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO's single write port among NUM_REQ write-domain producers.
// Latency: Req/Wfull -> Winc/Ack is combinational; from IDLE, one grant cycle precedes the first write.
// Backpressure: Wfull blocks the write and freezes the owner and burst count; no rotation while full.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int Data_width = 8,
   parameter int BURST      = 4
) (
   input  logic                          Wclk,
   input  logic                          Wrst,
   input  logic [NUM_REQ-1:0]            Req,
   input  logic [NUM_REQ*Data_width-1:0] Req_data,
   output logic [NUM_REQ-1:0]            Ack,
   output logic [NUM_REQ-1:0]            Gnt,
   input  logic                          Wfull,
   output logic                          Winc,
   output logic [Data_width-1:0]         Wrdata
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(BURST + 1);

   // After reset the pointer sits on the last requester so requester 0 is searched first.
   localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);
   localparam logic [IW:0]   NUM_EXT  = (IW + 1)'(NUM_REQ);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic [IW-1:0]   owner_q, owner_d;
   logic [IW-1:0]   last_q,  last_d;
   logic [CW-1:0]   cnt_q,   cnt_d;

   logic [IW-1:0]   pick_base;
   logic [IW-1:0]   winner;
   logic            found;
   logic [IW:0]     sum;
   logic [NUM_REQ-1:0]  owner_oh;
   logic [Data_width-1:0] lane_dat;
   logic            owner_req;
   logic            req_any;
   logic            burst_done;

   // Round-robin search. While granted, re-arbitration treats the current owner as the
   // last-served requester, so the search starts just after it; from IDLE it starts after last_q.
   always_comb begin
      pick_base = (state_q == S_GRANT) ? owner_q : last_q;
      winner    = pick_base;
      found     = 1'b0;
      sum       = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         sum = {1'b0, pick_base} + (IW + 1)'(k);
         if (sum >= NUM_EXT) begin
            sum = sum - NUM_EXT;
         end
         if (!found && Req[sum[IW-1:0]]) begin
            found  = 1'b1;
            winner = sum[IW-1:0];
         end
      end
   end

   // Owner decode and data lane selection for the current owner.
   always_comb begin
      owner_oh = '0;
      lane_dat = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner_q == IW'(i)) begin
            owner_oh[i] = 1'b1;
            lane_dat    = Req_data[i*Data_width +: Data_width];
         end
      end
      owner_req  = |(Req & owner_oh);
      req_any    = |Req;
      burst_done = (cnt_q == CNT_LAST);
   end

   // State register: FSM state, owner, last-served pointer and burst counter.
   always_ff @(posedge Wclk or negedge Wrst) begin
      if (!Wrst) begin
         state_q <= S_IDLE;
         owner_q <= '0;
         last_q  <= LAST_RST;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state: grant from IDLE, count words in a burst, re-arbitrate on burst end or release.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (req_any) begin
               state_d = S_GRANT;
               owner_d = winner;
               cnt_d   = '0;
            end
         end
         S_GRANT: begin
            // A full burst and an owner release both hand the port on; a release costs
            // one idle cycle because nothing was written while Req[owner] was low.
            if ((Winc && burst_done) || !owner_req) begin
               last_d = owner_q;
               cnt_d  = '0;
               if (req_any) begin
                  state_d = S_GRANT;
                  owner_d = winner;
               end else begin
                  state_d = S_IDLE;
               end
            end else if (Winc) begin
               cnt_d = cnt_q + CW'(1);
            end
            // Otherwise Wfull is holding a live owner: everything stays put.
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs: purely combinational from state and inputs, so a reset or Wfull drops Winc at once.
   always_comb begin
      Winc   = (state_q == S_GRANT) && owner_req && !Wfull;
      Gnt    = (state_q == S_GRANT) ? owner_oh : '0;
      Ack    = Winc ? owner_oh : '0;
      Wrdata = (state_q == S_GRANT) ? lane_dat : '0;
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a write scoreboard.
// Producers are modelled as per-lane word queues advanced on Ack.
// A negedge monitor pops the expected write queue on every Winc.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int B  = 4;

   logic            Wclk = 1'b0;
   logic            Wrst = 1'b0;
   logic [N-1:0]    Req = '0;
   logic [N*DW-1:0] Req_data = '0;
   logic [N-1:0]    Ack;
   logic [N-1:0]    Gnt;
   logic            Wfull = 1'b0;
   logic            Winc;
   logic [DW-1:0]   Wrdata;

   fifo_wr_arbiter #(.NUM_REQ(N), .Data_width(DW), .BURST(B)) dut (
      .Wclk(Wclk), .Wrst(Wrst), .Req(Req), .Req_data(Req_data), .Ack(Ack),
      .Gnt(Gnt), .Wfull(Wfull), .Winc(Winc), .Wrdata(Wrdata)
   );

   always #5 Wclk = ~Wclk;

   int checks = 0;
   int failures = 0;

   logic [DW-1:0] lane_q [N][$];
   logic [10:0]   exp_q [$];
   logic [N-1:0]  ack_s = '0;
   int cyc = 0;
   int wr_n = 0;
   int first_cyc = 0;
   int last_cyc = 0;
   int wr_idx = 0;

   function automatic logic [N-1:0] oh(input int i);
      return N'(1) << i;
   endfunction

   // Monitor: every presented write must match the next scoreboard entry.
   always @(negedge Wclk) begin
      logic [10:0] e;
      cyc++;
      ack_s = Ack;
      if (Winc) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write ack=%b gnt=%b data=%h required=no write", Ack, Gnt, Wrdata);
         end else begin
            e = exp_q.pop_front();
            if (Ack !== oh(int'(e[10:8])) || Gnt !== oh(int'(e[10:8])) || Wrdata !== e[7:0]) begin
               failures++;
               $display("FAIL write_%0d ack=%b gnt=%b data=%h required ack=gnt=%b data=%h",
                        wr_idx, Ack, Gnt, Wrdata, oh(int'(e[10:8])), e[7:0]);
            end
         end
         wr_idx++;
         if (wr_n == 0) first_cyc = cyc;
         last_cyc = cyc;
         wr_n++;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   // Called at posedge+1: settle and compare the combinational outputs mid-cycle.
   task automatic chk_outs(input string nm, input logic w, input logic [N-1:0] a, input logic [N-1:0] g);
      #2;
      chk({nm, "_winc"}, 32'(Winc), 32'(w));
      chk({nm, "_ack"},  32'(Ack),  32'(a));
      chk({nm, "_gnt"},  32'(Gnt),  32'(g));
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         Req[i] = (lane_q[i].size() != 0);
         Req_data[i*DW +: DW] = (lane_q[i].size() != 0) ? lane_q[i][0] : '0;
      end
   endtask

   // Advance one cycle; producers whose word was acknowledged present their next word.
   task automatic tick();
      @(posedge Wclk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (ack_s[i] && lane_q[i].size() != 0) void'(lane_q[i].pop_front());
      end
      drive();
   endtask

   task automatic push(input int l, input logic [7:0] d);
      exp_q.push_back({3'(l), d});
   endtask

   task automatic do_reset();
      Wrst  = 1'b0;
      Wfull = 1'b0;
      for (int i = 0; i < N; i++) lane_q[i].delete();
      exp_q.delete();
      drive();
      repeat (2) @(posedge Wclk);
      #1;
      Wrst = 1'b1;
      wr_n = 0;
   endtask

   task automatic drain(input string nm, input int budget);
      int k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         tick();
         k++;
      end
      chk({nm, "_drained"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      // Reset values, sampled while reset is asserted.
      Wrst = 1'b0;
      #3;
      chk("rst_winc",   32'(Winc),   32'd0);
      chk("rst_ack",    32'(Ack),    32'd0);
      chk("rst_gnt",    32'(Gnt),    32'd0);
      chk("rst_wrdata", 32'(Wrdata), 32'd0);

      // 1: single requester, six words across a burst boundary without a bubble.
      do_reset();
      for (int j = 0; j < 6; j++) begin
         lane_q[0].push_back(8'h11 + 8'(j));
         push(0, 8'h11 + 8'(j));
      end
      drive();
      chk_outs("t1_grant_cycle", 1'b0, 4'b0000, 4'b0000);
      drain("t1", 30);
      chk("t1_count", 32'(wr_n), 32'd6);
      chk("t1_span", 32'(last_cyc - first_cyc), 32'd5);
      tick();
      tick();
      chk_outs("t1_idle", 1'b0, 4'b0000, 4'b0000);

      // 2: requesters 0 and 2, blocks of four alternating with no gap.
      do_reset();
      for (int j = 0; j < 8; j++) lane_q[0].push_back(8'h01 + 8'(j));
      for (int j = 0; j < 4; j++) lane_q[2].push_back(8'h21 + 8'(j));
      for (int j = 0; j < 4; j++) push(0, 8'h01 + 8'(j));
      for (int j = 0; j < 4; j++) push(2, 8'h21 + 8'(j));
      for (int j = 4; j < 8; j++) push(0, 8'h01 + 8'(j));
      drive();
      drain("t2", 40);
      chk("t2_count", 32'(wr_n), 32'd12);
      chk("t2_span", 32'(last_cyc - first_cyc), 32'd11);

      // 3: all four requesting: order 0,1,2,3,0, four words each.
      do_reset();
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < 4; j++) lane_q[i].push_back(8'((i + 1) * 16 + j));
      end
      for (int j = 4; j < 8; j++) lane_q[0].push_back(8'(16 + j));
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < 4; j++) push(i, 8'((i + 1) * 16 + j));
      end
      for (int j = 4; j < 8; j++) push(0, 8'(16 + j));
      drive();
      drain("t3", 60);
      chk("t3_count", 32'(wr_n), 32'd20);
      chk("t3_span", 32'(last_cyc - first_cyc), 32'd19);

      // 4: owner 1 stalled by Wfull after two words; count is frozen, so only two
      //    more words before requester 2 gets its turn.
      do_reset();
      for (int j = 0; j < 6; j++) lane_q[1].push_back(8'h41 + 8'(j));
      lane_q[2].push_back(8'h71);
      push(1, 8'h41); push(1, 8'h42); push(1, 8'h43); push(1, 8'h44);
      push(2, 8'h71);
      push(1, 8'h45); push(1, 8'h46);
      drive();
      tick();
      tick();
      for (int j = 0; j < 3; j++) begin
         tick();
         Wfull = 1'b1;
         chk_outs($sformatf("t4_full%0d", j), 1'b0, 4'b0000, 4'b0010);
      end
      tick();
      Wfull = 1'b0;
      chk_outs("t4_resume", 1'b1, 4'b0010, 4'b0010);
      drain("t4", 30);
      chk("t4_count", 32'(wr_n), 32'd7);
      chk("t4_span", 32'(last_cyc - first_cyc), 32'd10);

      // 5: owner 0 releases after two words; one bubble then requester 3.
      do_reset();
      lane_q[0].push_back(8'h51);
      lane_q[0].push_back(8'h52);
      for (int j = 0; j < 4; j++) lane_q[3].push_back(8'h31 + 8'(j));
      push(0, 8'h51); push(0, 8'h52);
      for (int j = 0; j < 4; j++) push(3, 8'h31 + 8'(j));
      drive();
      tick();
      tick();
      tick();
      chk_outs("t5_bubble", 1'b0, 4'b0000, 4'b0001);
      tick();
      chk_outs("t5_switch", 1'b1, 4'b1000, 4'b1000);
      drain("t5", 30);
      chk("t5_span", 32'(last_cyc - first_cyc), 32'd6);

      // 6: reset mid-burst (owner 2, third word presented), then priority restarts at 0.
      do_reset();
      for (int j = 0; j < 4; j++) lane_q[2].push_back(8'h61 + 8'(j));
      push(2, 8'h61); push(2, 8'h62);
      drive();
      tick();
      tick();
      tick();
      chk("t6_inflight_winc", 32'(Winc), 32'd1);
      Wrst = 1'b0;
      #1;
      chk("t6_rst_winc", 32'(Winc), 32'd0);
      chk("t6_rst_gnt",  32'(Gnt),  32'd0);
      chk("t6_rst_ack",  32'(Ack),  32'd0);
      chk("t6_rst_data", 32'(Wrdata), 32'd0);
      @(negedge Wclk);
      chk("t6_unwritten", 32'(exp_q.size()), 32'd0);
      for (int i = 0; i < N; i++) lane_q[i].delete();
      drive();
      @(posedge Wclk);
      #1;
      Wrst = 1'b1;
      wr_n = 0;
      lane_q[1].push_back(8'h1a);
      lane_q[2].push_back(8'h2a);
      push(1, 8'h1a);
      push(2, 8'h2a);
      drive();
      tick();
      chk_outs("t6_first_gnt", 1'b1, 4'b0010, 4'b0010);
      drain("t6", 20);
      chk("t6_count", 32'(wr_n), 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
